// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, bit timing and TX arbiter state encoding.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    // Clocks per UART bit at 100 MHz / 115200 baud, shared by TX and RX sides.
    localparam int BAUD_TIMER = 868;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } tx_state_t;

    // Increment an index with an explicit wrap, so non-power-of-two counts work.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: first set mask bit scanning from i_ptr upward, wrapping at N.
module uart_rr_picker #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   i_mask,
    input  logic [IDW-1:0] i_ptr,
    output logic           o_found,
    output logic [IDW-1:0] o_winner
);

    logic [IDW-1:0] w_idx [N];
    logic [N-1:0]   w_hit;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_scan
            // Slot gi of the scan looks at requester (ptr + gi) mod N
            assign w_idx[gi] = (int'(i_ptr) + gi >= N) ? IDW'(int'(i_ptr) + gi - N)
                                                       : IDW'(int'(i_ptr) + gi);
            assign w_hit[gi] = i_mask[w_idx[gi]];
        end
    endgenerate

    // Priority-select the earliest hit in scan order
    always_comb begin
        o_found  = 1'b0;
        o_winner = '0;
        for (int k = 0; k < N; k++) begin
            if (!o_found && w_hit[k]) begin
                o_found  = 1'b1;
                o_winner = w_idx[k];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte sources,
// with packet locking and a lost-byte timeout while waiting for tx_ready to fall.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int IDW          = $clog2(N_REQ),
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [UART_DATA_W*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]             req_last,
    output logic [N_REQ-1:0]             req_ack,
    output logic                         tx_send,
    output logic [UART_DATA_W-1:0]       tx_data,
    input  logic                         tx_ready,
    output logic                         busy,
    output logic [IDW-1:0]               grant_id,
    output logic                         locked,
    output logic                         err_timeout
);

    localparam int CNT_W = $clog2(BUSY_TIMEOUT) + 1;

    tx_state_t              r_state;
    logic [N_REQ-1:0]       r_req_ack;
    logic                   r_tx_send;
    logic [UART_DATA_W-1:0] r_tx_data;
    logic                   r_busy;
    logic [IDW-1:0]         r_grant_id;
    logic                   r_locked;
    logic                   r_err_timeout;
    logic [IDW-1:0]         r_rr_ptr;
    logic [CNT_W-1:0]       r_cnt;

    logic [UART_DATA_W-1:0] w_bytes [N_REQ];
    logic [N_REQ-1:0]       w_owner_mask;
    logic [N_REQ-1:0]       w_cand;
    logic                   w_found;
    logic [IDW-1:0]         w_winner;
    logic [N_REQ-1:0]       w_win_onehot;
    logic [UART_DATA_W-1:0] w_win_data;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_bytes
            assign w_bytes[gi] = req_data[gi*UART_DATA_W +: UART_DATA_W];
        end
    endgenerate

    // While a packet is open only its owner may compete; grant_id names the owner
    assign w_owner_mask = N_REQ'(1) << r_grant_id;
    assign w_cand       = r_locked ? (req_valid & w_owner_mask) : req_valid;
    assign w_win_onehot = N_REQ'(1) << w_winner;
    assign w_win_data   = w_bytes[w_winner];

    uart_rr_picker #(
        .N   (N_REQ),
        .IDW (IDW)
    ) u_picker (
        .i_mask   (w_cand),
        .i_ptr    (r_rr_ptr),
        .o_found  (w_found),
        .o_winner (w_winner)
    );

    // Arbitration FSM: pick a winner, pulse send/ack once, then follow tx_ready through the frame
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_req_ack     <= '0;
            r_tx_send     <= 1'b0;
            r_tx_data     <= '0;
            r_busy        <= 1'b0;
            r_grant_id    <= '0;
            r_locked      <= 1'b0;
            r_err_timeout <= 1'b0;
            r_rr_ptr      <= '0;
            r_cnt         <= '0;
        end else begin
            r_tx_send     <= 1'b0;
            r_req_ack     <= '0;
            r_err_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (tx_ready && w_found) begin
                        r_tx_data  <= w_win_data;
                        r_tx_send  <= 1'b1;
                        r_req_ack  <= w_win_onehot;
                        r_grant_id <= w_winner;
                        r_rr_ptr   <= IDW'(wrap_inc(int'(w_winner), N_REQ));
                        r_locked   <= ~req_last[w_winner];
                        r_busy     <= 1'b1;
                        r_state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (!tx_ready) begin
                        r_state <= WAIT_DONE;
                    end else if (r_cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
                        // Transmitter never took the byte: drop it and release any packet lock
                        r_err_timeout <= 1'b1;
                        r_locked      <= 1'b0;
                        r_busy        <= 1'b0;
                        r_state       <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                WAIT_DONE: begin
                    if (tx_ready) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ack     = r_req_ack;
    assign tx_send     = r_tx_send;
    assign tx_data     = r_tx_data;
    assign busy        = r_busy;
    assign grant_id    = r_grant_id;
    assign locked      = r_locked;
    assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a transmitter model and a rule-level arbitration model.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int BT = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_last = '0;
    logic        tx_ready = 1'b1;
    logic [3:0]  req_ack;
    logic        tx_send;
    logic [7:0]  tx_data;
    logic        busy;
    logic [1:0]  grant_id;
    logic        locked;
    logic        err_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    // transmitter model control: 0 = normal frames, 1 = bench drives tx_ready by hand
    int tx_mode   = 0;
    int frame_len = 12;
    int tx_cnt    = 0;
    logic rdy_q = 1'b1;

    // arbitration reference model
    int m_ptr    = 0;
    bit m_locked = 0;
    int m_owner  = 0;

    uart_tx_arbiter #(.N_REQ(N), .IDW(2), .BUSY_TIMEOUT(BT)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ack     (req_ack),
        .tx_send     (tx_send),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .grant_id    (grant_id),
        .locked      (locked),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    // tx_ready as seen by the DUT at each rising edge
    always @(posedge clk) rdy_q <= tx_ready;

    // a send may only be launched by an edge where tx_ready was high
    always @(negedge clk) begin
        if (tx_send === 1'b1) begin
            n_checks++;
            if (rdy_q !== 1'b1) begin
                n_fail++;
                $display("FAIL send_while_not_ready: tx_ready at issuing edge=%b, required 1", rdy_q);
            end
        end
    end

    // transmitter: takes send at the next edge, ready low for frame_len cycles
    initial begin : tx_model
        logic s;
        forever begin
            @(negedge clk);
            s = tx_send;
            @(posedge clk);
            #2;
            if (tx_mode == 0) begin
                if (s === 1'b1) begin
                    tx_ready = 1'b0;
                    tx_cnt   = frame_len;
                end else if (tx_cnt > 0) begin
                    tx_cnt--;
                    if (tx_cnt == 0) tx_ready = 1'b1;
                end
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: time limit reached, n_checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    function automatic int model_pick(input logic [3:0] v);
        if (m_locked) return v[m_owner] ? m_owner : -1;
        for (int k = 0; k < N; k++) begin
            if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_grant(input int w, input bit last);
        m_ptr    = (w + 1) % N;
        m_owner  = w;
        m_locked = !last;
    endtask

    task automatic model_reset();
        m_ptr = 0; m_locked = 0; m_owner = 0;
    endtask

    function automatic logic [7:0] byte_of(input int w);
        logic [31:0] d;
        d = req_data;
        return d[8*w +: 8];
    endfunction

    task automatic arrive();
        for (int i = 0; i < N; i++) begin
            if (!req_valid[i] && $urandom_range(3) == 0) begin
                req_valid[i]      = 1'b1;
                req_data[8*i +: 8] = 8'($urandom);
                req_last[i]       = ($urandom_range(2) != 0);
            end
        end
    endtask

    task automatic wait_issue(input int max_cyc, input bit rnd, output bit ok,
                              output int waited, output int acks);
        ok = 0; waited = 0; acks = 0;
        while (!ok && waited < max_cyc) begin
            @(negedge clk);
            waited++;
            acks += $countones(req_ack);
            if (tx_send === 1'b1) ok = 1;
            else if (rnd) arrive();
        end
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 300; i++) begin
            @(negedge clk);
            if (busy === 1'b0 && tx_ready === 1'b1) break;
        end
        if (i == 300) begin
            n_checks++; n_fail++;
            $display("FAIL drain_timeout: busy=%b tx_ready=%b, required 0/1", busy, tx_ready);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        req_valid = '0;
        tx_mode = 0;
        if (tx_cnt == 0) tx_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < 200 && tx_ready !== 1'b1; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks += 7;
        if (req_ack !== 4'b0)     begin n_fail++; $display("FAIL reset_req_ack: got %b, required 0000", req_ack); end
        if (tx_send !== 1'b0)     begin n_fail++; $display("FAIL reset_tx_send: got %b, required 0", tx_send); end
        if (tx_data !== 8'h00)    begin n_fail++; $display("FAIL reset_tx_data: got %h, required 00", tx_data); end
        if (busy !== 1'b0)        begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
        if (grant_id !== 2'd0)    begin n_fail++; $display("FAIL reset_grant_id: got %0d, required 0", grant_id); end
        if (locked !== 1'b0)      begin n_fail++; $display("FAIL reset_locked: got %b, required 0", locked); end
        if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b, required 0", err_timeout); end
        reset = 1'b1;
        model_reset();
        $display("reset: outputs checked at reset values");
    endtask

    task automatic test_single_byte();
        bit ok; int w, a, exp, rise, fall, cyc, errs; bit seen_low;
        apply_reset();
        frame_len = 40;
        req_data = $urandom;
        req_data[23:16] = 8'hA5;
        req_last = 4'($urandom) | 4'b0100;
        req_valid = 4'b0100;
        exp = model_pick(req_valid);
        wait_issue(20, 0, ok, w, a);
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL single_issue: no tx_send within 20 cycles, required one");
            return;
        end
        n_checks += 5;
        if (req_ack !== 4'(4'b0001 << exp)) begin n_fail++; $display("FAIL single_ack: got %b, required %b", req_ack, 4'(4'b0001 << exp)); end
        if (tx_data !== 8'hA5)              begin n_fail++; $display("FAIL single_data: got %h, required a5", tx_data); end
        if (grant_id !== 2'd2)              begin n_fail++; $display("FAIL single_grant: got %0d, required 2", grant_id); end
        if (busy !== 1'b1)                  begin n_fail++; $display("FAIL single_busy: got %b, required 1", busy); end
        if (locked !== 1'b0)                begin n_fail++; $display("FAIL single_locked: got %b, required 0", locked); end
        model_grant(exp, req_last[exp]);
        req_valid = '0;
        rise = -1; fall = -1; errs = 0; seen_low = 0;
        for (cyc = 1; cyc <= 100; cyc++) begin
            @(negedge clk);
            if (err_timeout === 1'b1) errs++;
            if (tx_ready === 1'b0) seen_low = 1;
            if (tx_ready === 1'b1 && seen_low && rise < 0) rise = cyc;
            if (busy === 1'b0) begin fall = cyc; break; end
        end
        n_checks += 3;
        if (rise < 0 || fall != rise + 1) begin n_fail++; $display("FAIL single_busy_fall: busy fell at %0d, ready rose at %0d, required rise+1", fall, rise); end
        if (errs != 0)                      begin n_fail++; $display("FAIL single_no_err: err pulses=%0d, required 0", errs); end
        if (tx_data !== 8'hA5)              begin n_fail++; $display("FAIL single_data_hold: got %h, required a5", tx_data); end
        $display("single_byte: grant=%0d data=%h busy_fall=%0d ready_rise=%0d", grant_id, tx_data, fall, rise);
    endtask

    task automatic test_fairness();
        bit ok; int w, a, exp, total;
        apply_reset();
        frame_len = $urandom_range(3, 9);
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        req_data  = $urandom;
        total = 0;
        for (int t = 0; t < 8; t++) begin
            exp = model_pick(req_valid);
            wait_issue(100, 0, ok, w, a);
            total += a;
            if (!ok) begin
                n_checks++; n_fail++;
                $display("FAIL fair_issue: frame %0d not issued within 100 cycles", t);
                break;
            end
            n_checks += 3;
            if (grant_id !== 2'(t % 4))          begin n_fail++; $display("FAIL fair_order: frame %0d grant=%0d, required %0d", t, grant_id, t % 4); end
            if (req_ack !== 4'(4'b0001 << exp))  begin n_fail++; $display("FAIL fair_ack: got %b, required %b", req_ack, 4'(4'b0001 << exp)); end
            if (tx_data !== byte_of(exp))        begin n_fail++; $display("FAIL fair_data: got %h, required %h", tx_data, byte_of(exp)); end
            $display("fairness: frame %0d grant=%0d data=%h", t, grant_id, tx_data);
            model_grant(exp, 1'b1);
            req_data[8*exp +: 8] = 8'($urandom);
            if (t == 7) req_valid = '0;
        end
        for (int i = 0; i < 100 && busy !== 1'b0; i++) begin
            @(negedge clk);
            total += $countones(req_ack);
        end
        n_checks++;
        if (total != 8) begin n_fail++; $display("FAIL fair_ack_count: got %0d, required 8", total); end
    endtask

    task automatic test_packet_lock();
        bit ok; int w, a, exp, gap, sends;
        apply_reset();
        frame_len = $urandom_range(3, 8);
        req_data  = $urandom;
        req_last  = 4'b1000;
        req_valid = 4'b1010;
        for (int b = 0; b < 3; b++) begin
            req_last[1] = (b == 2);
            req_data[15:8] = 8'($urandom);
            exp = model_pick(req_valid);
            wait_issue(100, 0, ok, w, a);
            if (!ok) begin
                n_checks++; n_fail++;
                $display("FAIL lock_issue: byte %0d not issued", b);
                return;
            end
            model_grant(exp, req_last[exp]);
            n_checks += 3;
            if (grant_id !== 2'd1)        begin n_fail++; $display("FAIL lock_grant: byte %0d grant=%0d, required 1", b, grant_id); end
            if (tx_data !== byte_of(exp)) begin n_fail++; $display("FAIL lock_data: got %h, required %h", tx_data, byte_of(exp)); end
            if (locked !== m_locked)      begin n_fail++; $display("FAIL lock_flag: byte %0d locked=%b, required %b", b, locked, m_locked); end
            $display("packet_lock: byte %0d grant=%0d locked=%b", b, grant_id, locked);
            if (b == 0) begin
                req_valid[1] = 1'b0;
                gap = $urandom_range(20, 40);
                sends = 0;
                repeat (gap) begin
                    @(negedge clk);
                    if (tx_send === 1'b1) sends++;
                end
                n_checks++;
                if (sends != 0) begin n_fail++; $display("FAIL lock_stall: %0d sends while owner idle, required 0", sends); end
                req_valid[1] = 1'b1;
            end
        end
        req_valid[1] = 1'b0;
        exp = model_pick(req_valid);
        wait_issue(100, 0, ok, w, a);
        n_checks += 3;
        if (!ok || grant_id !== 2'd3) begin n_fail++; $display("FAIL lock_release_grant: grant=%0d issued=%b, required 3", grant_id, ok); end
        if (locked !== 1'b0)          begin n_fail++; $display("FAIL lock_release_flag: got %b, required 0", locked); end
        if (tx_data !== byte_of(exp)) begin n_fail++; $display("FAIL lock_release_data: got %h, required %h", tx_data, byte_of(exp)); end
        model_grant(exp, 1'b1);
        req_valid = '0;
        $display("packet_lock: released, grant=%0d", grant_id);
        drain();
    endtask

    task automatic test_timeout();
        bit ok; int w, a, exp, first, errs;
        apply_reset();
        tx_mode = 1;
        tx_ready = 1'b1;
        req_data = $urandom;
        req_data[7:0] = 8'h3C;
        req_last = 4'b0000;
        req_valid = 4'b0001;
        exp = model_pick(req_valid);
        wait_issue(20, 0, ok, w, a);
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL timeout_issue: no send within 20 cycles");
            return;
        end
        model_grant(exp, req_last[exp]);
        n_checks += 2;
        if (tx_data !== 8'h3C)   begin n_fail++; $display("FAIL timeout_data: got %h, required 3c", tx_data); end
        if (locked !== m_locked) begin n_fail++; $display("FAIL timeout_lock_set: got %b, required %b", locked, m_locked); end
        req_valid = '0;
        first = -1; errs = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (err_timeout === 1'b1) begin
                errs++;
                if (first < 0) first = k;
            end
        end
        m_locked = 0;
        n_checks += 4;
        if (first != BT + 1)     begin n_fail++; $display("FAIL timeout_when: err at %0d cycles after send, required %0d", first, BT + 1); end
        if (errs != 1)           begin n_fail++; $display("FAIL timeout_pulse: %0d err cycles, required 1", errs); end
        if (busy !== 1'b0)       begin n_fail++; $display("FAIL timeout_idle: busy=%b, required 0", busy); end
        if (locked !== m_locked) begin n_fail++; $display("FAIL timeout_unlock: locked=%b, required %b", locked, m_locked); end
        $display("timeout: err after %0d cycles, locked=%b", first, locked);
        tx_mode = 0; tx_cnt = 0;
        req_data[31:24] = 8'($urandom);
        req_last[3] = 1'b1;
        req_valid = 4'b1000;
        exp = model_pick(req_valid);
        wait_issue(20, 0, ok, w, a);
        n_checks += 2;
        if (!ok || req_ack !== 4'(4'b0001 << exp)) begin n_fail++; $display("FAIL timeout_next_ack: got %b issued=%b, required %b", req_ack, ok, 4'(4'b0001 << exp)); end
        if (tx_data !== byte_of(exp))              begin n_fail++; $display("FAIL timeout_next_data: got %h, required %h", tx_data, byte_of(exp)); end
        model_grant(exp, 1'b1);
        req_valid = '0;
        $display("timeout: next request grant=%0d data=%h", grant_id, tx_data);
        drain();
    endtask

    task automatic test_not_ready();
        int sends, acks, exp;
        apply_reset();
        tx_mode = 1;
        tx_ready = 1'b0;
        req_data = $urandom;
        req_last = 4'b0100;
        req_valid = 4'b0100;
        sends = 0; acks = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx_send === 1'b1) sends++;
            acks += $countones(req_ack);
        end
        n_checks += 2;
        if (sends != 0) begin n_fail++; $display("FAIL notready_send: %0d sends, required 0", sends); end
        if (acks != 0)  begin n_fail++; $display("FAIL notready_ack: %0d acks, required 0", acks); end
        exp = model_pick(req_valid);
        tx_ready = 1'b1;
        @(negedge clk);
        n_checks += 2;
        if (tx_send !== 1'b1)                begin n_fail++; $display("FAIL notready_latency: tx_send=%b one cycle after ready, required 1", tx_send); end
        if (req_ack !== 4'(4'b0001 << exp))  begin n_fail++; $display("FAIL notready_ack_after: got %b, required %b", req_ack, 4'(4'b0001 << exp)); end
        $display("not_ready: send=%b ack=%b after ready rose", tx_send, req_ack);
        model_grant(exp, 1'b1);
        req_valid = '0;
        tx_ready = 1'b0;
        repeat (5) @(negedge clk);
        tx_ready = 1'b1;
        drain();
        tx_mode = 0;
    endtask

    task automatic test_reset_mid_frame();
        bit ok; int w, a, exp;
        apply_reset();
        frame_len = 30;
        req_data  = $urandom;
        req_last  = 4'b1000;
        req_valid = 4'b1001;
        exp = model_pick(req_valid);
        wait_issue(20, 0, ok, w, a);
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL midreset_issue: no send within 20 cycles");
            return;
        end
        model_grant(exp, req_last[exp]);
        req_valid = 4'b1000;
        for (int i = 0; i < 20 && tx_ready !== 1'b0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        n_checks += 2;
        if (locked !== 1'b1) begin n_fail++; $display("FAIL midreset_pre_lock: got %b, required 1", locked); end
        if (busy !== 1'b1)   begin n_fail++; $display("FAIL midreset_pre_busy: got %b, required 1", busy); end
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        n_checks += 4;
        if (locked !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL midreset_async: locked=%b busy=%b, required 0/0", locked, busy); end
        if (tx_data !== 8'h00)                begin n_fail++; $display("FAIL midreset_data: got %h, required 00", tx_data); end
        if (grant_id !== 2'd0)                begin n_fail++; $display("FAIL midreset_grant: got %0d, required 0", grant_id); end
        if (tx_send !== 1'b0 || req_ack !== 4'b0 || err_timeout !== 1'b0) begin
            n_fail++; $display("FAIL midreset_pulses: send=%b ack=%b err=%b, required 0", tx_send, req_ack, err_timeout);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        exp = model_pick(req_valid);
        wait_issue(100, 0, ok, w, a);
        n_checks += 3;
        if (!ok || grant_id !== 2'(exp)) begin n_fail++; $display("FAIL midreset_regrant: grant=%0d issued=%b, required %0d", grant_id, ok, exp); end
        if (a != 1)                      begin n_fail++; $display("FAIL midreset_ack_count: %0d acks, required 1", a); end
        if (locked !== 1'b0)             begin n_fail++; $display("FAIL midreset_post_lock: got %b, required 0", locked); end
        model_grant(exp, 1'b1);
        req_valid = '0;
        $display("reset_mid_frame: regrant=%0d locked=%b", grant_id, locked);
        drain();
    endtask

    task automatic test_random();
        bit ok; int w, a, exp;
        apply_reset();
        req_last = '0;
        for (int tr = 0; tr < 40; tr++) begin
            frame_len = $urandom_range(1, 6);
            wait_issue(300, 1, ok, w, a);
            if (!ok) begin
                n_checks++; n_fail++;
                $display("FAIL rand_issue: transaction %0d not issued within 300 cycles", tr);
                break;
            end
            exp = model_pick(req_valid);
            n_checks++;
            if (exp < 0 || req_ack !== 4'(4'b0001 << exp) || grant_id !== 2'(exp) || tx_data !== byte_of(exp)) begin
                n_fail++;
                $display("FAIL rand_grant: tr %0d ack=%b grant=%0d data=%h, required winner %0d", tr, req_ack, grant_id, tx_data, exp);
                break;
            end
            model_grant(exp, req_last[exp]);
            n_checks++;
            if (locked !== m_locked) begin n_fail++; $display("FAIL rand_lock: tr %0d locked=%b, required %b", tr, locked, m_locked); end
            $display("random: tr %0d grant=%0d data=%h locked=%b", tr, grant_id, tx_data, locked);
            req_valid[exp] = 1'b0;
        end
        req_valid = '0;
        drain();
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_fairness();
        test_packet_lock();
        test_timeout();
        test_not_ready();
        test_reset_mid_frame();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
